// File: rtl/key_sequencer.sv
// key_sequencer: sends a latched N-symbol code, one 2-bit symbol at a time,
// to the combination lock. It then watches the lock's unlocked feedback and
// retries on timeout, up to MAX_TRY attempts. It reports pass or fail with a
// one-cycle done pulse.
module key_sequencer #(
  parameter int N_SYM    = 4,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 1,
  parameter int TIMEOUT  = 16,
  parameter int MAX_TRY  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2*N_SYM-1:0]           code,
  input  logic                         unlocked,
  output logic [1:0]                   s,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [$clog2(MAX_TRY+1)-1:0] try_cnt
);

  localparam int TW    = $clog2(MAX_TRY + 1);
  localparam int MAXHG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAXC  = (MAXHG > TIMEOUT) ? MAXHG : TIMEOUT;
  // A single phase counter is shared by DRIVE, GAP and WAIT, so it is sized
  // for the longest of the three.
  localparam int CW    = $clog2(MAXC + 1);
  localparam int KW    = (N_SYM > 1) ? $clog2(N_SYM) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    GAP   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_r;
  logic [2*N_SYM-1:0] code_r;
  logic [KW-1:0]      k_r;
  logic [CW-1:0]      cnt_r;

  // Extract symbol idx from a packed code word.
  function automatic logic [1:0] sym_at(input logic [2*N_SYM-1:0] c,
                                        input logic [KW-1:0] idx);
    return c[2*idx +: 2];
  endfunction

  // Sequencer FSM. All outputs are registered. Each output is updated on the
  // same edge as the state change, so s shows the new state's symbol in the
  // first cycle of that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      code_r  <= '0;
      k_r     <= '0;
      cnt_r   <= '0;
      s       <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      try_cnt <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          s    <= 2'b00;
          if (start) begin
            code_r  <= code;
            k_r     <= '0;
            cnt_r   <= '0;
            try_cnt <= TW'(1);
            pass    <= 1'b0;
            fail    <= 1'b0;
            busy    <= 1'b1;
            s       <= code[1:0];
            state_r <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_r == CW'(HOLD_CYC - 1)) begin
            cnt_r   <= '0;
            s       <= 2'b00;
            state_r <= GAP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        GAP: begin
          if (cnt_r == CW'(GAP_CYC - 1)) begin
            cnt_r <= '0;
            if (k_r != KW'(N_SYM - 1)) begin
              k_r     <= k_r + KW'(1);
              s       <= sym_at(code_r, k_r + KW'(1));
              state_r <= DRIVE;
            end else begin
              state_r <= WAIT;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        WAIT: begin
          if (unlocked) begin
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
            state_r <= DONE;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            cnt_r <= '0;
            if (try_cnt < TW'(MAX_TRY)) begin
              try_cnt <= try_cnt + TW'(1);
              k_r     <= '0;
              s       <= code_r[1:0];
              state_r <= DRIVE;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              fail    <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          try_cnt <= '0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          s       <= 2'b00;
          try_cnt <= '0;
        end
      endcase
    end
  end

endmodule
